// File: rtl/alu_bist_ctrl.sv
// Built-in self-test sequencer for an 8-bit ALU: LFSR operand pairs, full opcode
// sweep per pair, MISR compaction of result and zero flag, golden-signature verdict.
module alu_bist_ctrl #(
  parameter int unsigned PATTERNS   = 256,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        zero_err,
  output logic [15:0] signature
);

  localparam logic [15:0] LAST_PAT  = 16'(PATTERNS - 1);
  localparam logic [15:0] MISR_INIT = 16'hFFFF;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [2:0]  OP_NOP    = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [2:0]  opcnt_q, opcnt_d;
  logic [15:0] patcnt_q, patcnt_d;
  logic        pass_q, pass_d;
  logic        zero_err_q, zero_err_d;

  logic [15:0] lfsr_step;
  logic [15:0] misr_step;
  logic        zero_bad;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign misr_step = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : 16'h0000)
                   ^ {7'b0, alu_zero, alu_result};
  assign zero_bad  = alu_zero != (alu_result == 8'h00);

  // NOTE: all state uses <= so every flop samples pre-edge values; the reset is
  // synchronous and therefore lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      misr_q     <= MISR_INIT;
      opcnt_q    <= 3'd0;
      patcnt_q   <= 16'd0;
      pass_q     <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      opcnt_q    <= opcnt_d;
      patcnt_q   <= patcnt_d;
      pass_q     <= pass_d;
      zero_err_q <= zero_err_d;
    end
  end

  // The start request is captured in a flop and launches the run one cycle later,
  // giving done exactly 8*PATTERNS+2 edges after start is sampled.
  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    misr_d     = misr_q;
    opcnt_d    = opcnt_q;
    patcnt_d   = patcnt_q;
    pass_d     = pass_q;
    zero_err_d = zero_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          state_d    = RUN;
          lfsr_d     = LFSR_SEED;
          misr_d     = MISR_INIT;
          opcnt_d    = 3'd0;
          patcnt_d   = 16'd0;
          pass_d     = 1'b0;
          zero_err_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          misr_d  = misr_step;
          opcnt_d = opcnt_q + 3'd1;
          if (zero_bad) zero_err_d = 1'b1;
          if (opcnt_q == 3'd7) begin
            lfsr_d   = lfsr_step;
            patcnt_d = patcnt_q + 16'd1;
            if (patcnt_q == LAST_PAT) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          pass_d  = (misr_q == GOLDEN_SIG) && !zero_err_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stimulus is driven only in RUN; everywhere else the ALU sees a NOP.
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sel = OP_NOP;
    if (state_q == RUN) begin
      alu_a   = lfsr_q[15:8];
      alu_b   = lfsr_q[7:0];
      alu_sel = opcnt_q;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign zero_err  = zero_err_q;
  assign signature = misr_q;

endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL have parameter PATTERNS, default 256, meaning the number of LFSR operand pairs applied per run (legal 1..65535).
REQ-002 SHALL have parameter GOLDEN_SIG, default 16'h0000, meaning the expected final MISR signature.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the operand LFSR start value (nonzero).
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit, the rising-edge clock for all state.
REQ-006 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, which requests a self-test run.
REQ-008 SHALL have port abort, input, 1 bit, which cancels a run in progress.
REQ-009 SHALL have port alu_a, output, 8 bits, the ALU operand A.
REQ-010 SHALL have port alu_b, output, 8 bits, the ALU operand B.
REQ-011 SHALL have port alu_sel, output, 3 bits, the ALU opcode.
REQ-012 SHALL have port alu_result, input, 8 bits, the combinational ALU result.
REQ-013 SHALL have port alu_zero, input, 1 bit, the ALU zero flag.
REQ-014 SHALL have port busy, output, 1 bit, high while a run is active (RUN or CHECK).
REQ-015 SHALL have port done, output, 1 bit, high in DONE.
REQ-016 SHALL have port pass, output, 1 bit, the run verdict, valid while done=1.
REQ-017 SHALL have port zero_err, output, 1 bit, a sticky zero-flag consistency error.
REQ-018 SHALL have port signature, output, 16 bits, the current MISR value.

Function
REQ-019 SHALL have states IDLE, RUN, CHECK and DONE.
REQ-020 SHALL transition IDLE->RUN on start=1, loading lfsr=LFSR_SEED, misr=16'hFFFF, opcnt=0, patcnt=0, zero_err=0 and pass=0.
REQ-021 SHALL, in RUN, drive alu_a=lfsr[15:8], alu_b=lfsr[7:0], alu_sel=opcnt combinationally from registers; outside RUN it SHALL drive alu_a=0, alu_b=0, alu_sel=3'b111 (NOP).
REQ-022 SHALL, on every RUN cycle, update misr_next = (misr<<1) ^ (misr[15] ? 16'h1021 : 0) ^ {7'b0, alu_zero, alu_result}, sampling the ALU response in the same cycle the stimulus is driven.
REQ-023 SHALL, on every RUN cycle, set zero_err when alu_zero != (alu_result==8'h00); zero_err is cleared only by reset or a new start.
REQ-024 SHALL increment opcnt every RUN cycle, wrapping 7->0; on opcnt==7 it SHALL advance lfsr = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]} and increment patcnt.
REQ-025 SHALL move RUN->CHECK when opcnt==7 and patcnt==PATTERNS-1, so RUN lasts exactly 8*PATTERNS cycles.
REQ-026 SHALL, in CHECK (1 cycle), register pass = (misr==GOLDEN_SIG) && !zero_err, then move to DONE.
REQ-027 SHALL hold DONE, done=1, pass and signature stable until start=1, which SHALL restart as in IDLE->RUN.
REQ-028 SHALL ignore start in RUN and CHECK.
REQ-029 SHALL, on abort=1 in RUN or CHECK, go to IDLE next cycle with done=0 and pass=0; abort takes priority over the RUN->CHECK transition; abort is ignored in IDLE and DONE.
REQ-030 SHALL complete with latency from a start sampled at edge k to done=1 after edge k+8*PATTERNS+2.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, go to IDLE with busy=0, done=0, pass=0, zero_err=0, signature=16'hFFFF, lfsr=LFSR_SEED, opcnt=0, patcnt=0 and outputs at NOP values (a=0, b=0, sel=7).
REQ-032 SHALL give rst priority over start and abort, including mid-RUN.

Verification
REQ-033 SHALL be checked with PATTERNS=1 and a behavioural ALU: start -> 8 RUN cycles with a=AC, b=E1, sel 0..7, results 8D, CB, A0, ED, 4D, 2C, 00(z=1), 00(z=1); done rises 10 cycles after start and signature matches the model.
REQ-034 SHALL be checked with GOLDEN_SIG set to the model signature at default PATTERNS: done after 2050 cycles with pass=1 and zero_err=0.
REQ-035 SHALL be checked with a stuck-at-0 fault injected on alu_result[3]: pass=0, signature != GOLDEN_SIG, zero_err=0.
REQ-036 SHALL be checked with alu_zero forced to 0 for one cycle when sel=6 (result 00): zero_err=1 sticky and pass=0.
REQ-037 SHALL be checked with abort at RUN cycle 5, then start: it returns to IDLE with NOP outputs, and the restarted run yields the same signature as an uninterrupted run.
REQ-038 SHALL be checked with rst asserted mid-RUN and with start held high throughout RUN: rst gives the full reset state next cycle, and the extra start has no effect on sequencing.
